// File: rtl/agn_pkg.sv
// Shared definitions for the multi-waveform generator family.
package agn_pkg;

  typedef enum logic [1:0] {
    MODE_SAW = 2'd0,
    MODE_TRI = 2'd1,
    MODE_SQR = 2'd2,
    MODE_RMP = 2'd3
  } mode_e;

  // Clamp value to the largest number representable in width bits.
  function automatic logic [63:0] sat(input logic [63:0] value, input int width);
    logic [63:0] lim;
    lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value > lim) ? lim : value;
  endfunction

endpackage

// File: rtl/agn_msat.sv
// Modulate a wave sample by m, rescale by 2^MSH and saturate to W bits.
module agn_msat
  import agn_pkg::*;
#(
  parameter int W   = 12,
  parameter int MW  = 8,
  parameter int MSH = 7
) (
  input  logic [W-1:0]  wave,
  input  logic [MW-1:0] m,
  output logic [W-1:0]  scaled
);

  logic [W+MW-1:0] prod;
  logic [W+MW-1:0] shr;

  // Full-width product so large gains clamp instead of wrapping.
  always_comb begin
    prod   = (W+MW)'(wave) * (W+MW)'(m);
    shr    = prod >> MSH;
    scaled = W'(sat(64'(shr), W));
  end

endmodule

// File: rtl/agn_mwave.sv
// Multi-waveform generator: ce-stepped phase counter, shadowed period/step/mode,
// wave select, amplitude modulation and registered output with period-end flag.
module agn_mwave
  import agn_pkg::*;
#(
  parameter int W   = 12,
  parameter int NPW = 16,
  parameter int MW  = 8,
  parameter int MSH = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic [NPW-1:0] np,
  input  logic [W-1:0]   k,
  input  logic [1:0]     mode,
  input  logic [MW-1:0]  m,
  output logic [W-1:0]   out,
  output logic           co
);

  localparam int PW = NPW + W + 1;

  logic [NPW-1:0] cb, np_s, half, dn;
  logic [W-1:0]   k_s;
  mode_e          mode_s;
  logic           at_end, up_half;
  logic [PW-1:0]  saw_w, rmp_w, tri_w, sqr_w, sel_w;
  logic [W-1:0]   wave, scaled;

  assign at_end = (cb == np_s);

  // Phase counter; period, step and mode only change at the wrap (or reset).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cb     <= '0;
      np_s   <= np;
      k_s    <= k;
      mode_s <= mode_e'(mode);
    end else if (ce) begin
      if (at_end) begin
        cb     <= '0;
        np_s   <= np;
        k_s    <= k;
        mode_s <= mode_e'(mode);
      end else begin
        cb <= NPW'(cb + 1);
      end
    end
  end

  // Wave shapes at full product width, then clamp to a W-bit sample.
  always_comb begin
    half    = np_s >> 1;
    dn      = np_s - cb;
    up_half = (cb <= half);
    saw_w   = PW'(cb) * PW'(k_s);
    rmp_w   = PW'(dn) * PW'(k_s);
    tri_w   = up_half ? (saw_w << 1) : (rmp_w << 1);
    sqr_w   = up_half ? (PW'(np_s) * PW'(k_s)) : '0;
    case (mode_s)
      MODE_SAW: sel_w = saw_w;
      MODE_TRI: sel_w = tri_w;
      MODE_SQR: sel_w = sqr_w;
      default:  sel_w = rmp_w;
    endcase
    wave = W'(sat(64'(sel_w), W));
  end

  agn_msat #(.W(W), .MW(MW), .MSH(MSH)) u_msat (
    .wave   (wave),
    .m      (m),
    .scaled (scaled)
  );

  // Output stage runs every clock so m changes show up even with ce low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= '0;
      co  <= 1'b0;
    end else begin
      out <= scaled;
      co  <= at_end;
    end
  end

endmodule

// File: doc/agn_mwave.md
Name: agn_mwave

Overview:
- Parametrised multi-waveform amplitude-modulated generator; the next generation of the saw generator used in the signal-generator labs.
- Produces a sawtooth, triangle, square or falling ramp from a ce-stepped phase counter with runtime-programmable period and step.
- Scales each sample by a modulation word and saturates it; registers the output and the period-end flag.
- Feeds the DAC/display path, and can chain to further generators via co.

Parameters:
- W, 12, sample width of the wave and of out.
- NPW, 16, width of the period counter and of np.
- MW, 8, width of the modulation word m.
- MSH, 7, right shift applied after multiplying by m (m = 2^MSH is unity gain).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ce  in  1  step enable; the phase counter advances only when ce=1.
- np  in  NPW  period: the counter runs 0..np, giving np+1 steps.
- k  in  W  amplitude step per count.
- mode  in  2  0 saw, 1 triangle, 2 square, 3 falling ramp.
- m  in  MW  modulation multiplier, sampled every cycle.
- out  out  W  registered modulated sample.
- co  out  1  registered flag, high while the sampled counter equals its period end.

Behaviour:
- One clock; reset is synchronous and active-low. Port names are clk and rst_n.
- Reset (rst_n=0 at a clk edge): cb=0, out=0, co=0. The shadow registers np_s, k_s and mode_s load the current np, k and mode.
- Shadow update: np_s, k_s and mode_s also load np, k and mode at an edge where ce=1 and cb==np_s. Input changes mid-period are ignored until the wrap.
- Counter: at an edge with ce=1, cb <= (cb==np_s) ? 0 : cb+1. With ce=0, cb and the shadows hold.
- np=0: cb stays at 0 and co stays 1 after the first update.
- Wave, combinational from cb and the shadows, with half = np_s>>1:
  - saw = cb*k_s
  - rmp = (np_s-cb)*k_s
  - tri = (cb<=half) ? cb*2*k_s : (np_s-cb)*2*k_s
  - sqr = (cb<=half) ? np_s*k_s : 0
- All wave products are formed at NPW+W+1 bits, then saturated to 2^W-1.
- Modulation: prod = wave*m at W+MW bits; scaled = prod>>MSH, saturated to 2^W-1. There is no wrap-around, unlike the previous generation, which truncated.
- Output register: updated every clk regardless of ce, with latency 1.
  - out(t+1) = scaled(cb(t), shadows(t), m(t)).
  - co(t+1) = (cb(t)==np_s(t)).
  - out and co are therefore mutually aligned; co marks the sample taken at the period end.
- A change of m takes effect on the next out, including mid-period.
- Reset mid-period: the counter restarts at 0. The first out after rst_n returns high reflects cb=0 with the newly loaded shadows.
- ce held low: out keeps tracking m at the frozen cb.

Decomposition:
- Package agn_pkg:
  - MODE_SAW=2'd0, MODE_TRI=2'd1, MODE_SQR=2'd2, MODE_RMP=2'd3
  - function sat(value, width) returning min(value, 2^width-1)
- Sub-module agn_msat (parameters W, MW, MSH): combinational multiply, shift and saturate of wave by m. It is instantiated once and reused by future generators.
- The counter, shadows, wave mux and output register stay in agn_mwave.

Test Plan:
- Saw unity gain: np=100, k=40, mode=0, m=128, ce=1.
  - out = 0, 40, 80, …, 4000, then 0.
  - co=1 only on the out=4000 sample; period is 101 clocks.
- Saturation: same setup with m=255.
  - At cb=100, 4000*255>>7 = 7968, so out=4095.
  - At cb=50, 2000*255>>7 = 3984.
- Triangle and square: np=10, k=100.
  - mode=1: out = 0, 200, 400, 600, 800, 1000, 800, 600, 400, 200, 0.
  - mode=2: 1000 for cb 0..5, 0 for cb 6..10.
  - mode=3: 1000 down to 0 in steps of 100.
- Mid-period reprogramming: np=100, k=40. At cb=50, set np=20, k=10, mode=1.
  - The period completes through out=4000.
  - The next period is 21 steps of the triangle, peaking at 200 at cb=10.
- Enable and reset: ce toggled 1/0 alternately → each counter value is held for 2 clocks.
  - rst_n=0 for one clk at cb=37 → next out=0, co=0, and counting resumes from cb=0.
  - np=0 → co stays 1 and out=0 in every mode.
